pcpi_cmd_initiator: RTL and testbench

//  Initiator (core side) of the PCPI coprocessor interface. Accepts one custom-insn command
//  (insn, rs1, rs2) on a valid/ready port, drives it onto PCPI, then waits for pcpi_ready or
//  a timeout. It returns rd/wr/err on a valid/ready response port. Sits between a bus-mapped

---
 rtl/pcpi_cmd_initiator.sv | 144 ++++++++++++++
 tb/tb_pcpi_cmd_initiator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : pcpi_cmd_initiator
// Description : Core-side PCPI initiator. Takes one command on a valid/ready
//               port, presents it on PCPI, waits for pcpi_ready or a timeout,
//               then returns rd/wr/err on a valid/ready response port.
//               Optional macro PCPI_INIT_LATENCY_EN adds the rsp_cycles output.
// Revision    : 1.0 - initial release
// ============================================================================
module pcpi_cmd_initiator #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_insn,
    input  logic [31:0]       cmd_rs1,
    input  logic [31:0]       cmd_rs2,
    output logic              pcpi_valid,
    output logic [31:0]       pcpi_insn,
    output logic [31:0]       pcpi_rs1,
    output logic [31:0]       pcpi_rs2,
    input  logic              pcpi_wr,
    input  logic [31:0]       pcpi_rd,
    input  logic              pcpi_wait,
    input  logic              pcpi_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rd,
    output logic              rsp_wr,
    output logic              rsp_err
`ifdef PCPI_INIT_LATENCY_EN
    ,
    output logic [CNT_W-1:0]  rsp_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_timeout;
    logic             w_issue_done;

    assign cmd_ready    = (r_state == S_IDLE);
    assign w_accept     = cmd_ready && cmd_valid;
    // Ready takes priority over a timeout landing in the same cycle.
    assign w_timeout    = (r_state == S_ISSUE) && !pcpi_ready && !pcpi_wait
                          && (r_cnt == c_to_last);
    assign w_issue_done = (r_state == S_ISSUE) && (pcpi_ready || w_timeout);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            pcpi_valid <= 1'b0;
            pcpi_insn  <= '0;
            pcpi_rs1   <= '0;
            pcpi_rs2   <= '0;
            rsp_valid  <= 1'b0;
            rsp_rd     <= '0;
            rsp_wr     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        pcpi_insn  <= cmd_insn;
                        pcpi_rs1   <= cmd_rs1;
                        pcpi_rs2   <= cmd_rs2;
                        pcpi_valid <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pcpi_ready) begin
                        rsp_rd     <= pcpi_wr ? pcpi_rd : 32'd0;
                        rsp_wr     <= pcpi_wr;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        pcpi_valid <= 1'b0;
                        r_state    <= S_RESP;
                    end else if (w_timeout) begin
                        rsp_rd     <= '0;
                        rsp_wr     <= 1'b0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        pcpi_valid <= 1'b0;
                        r_state    <= S_RESP;
                    end else if (!pcpi_wait) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_GAP;
                    end
                end
                // Swallows the late duplicate ready of a registered responder.
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PCPI_INIT_LATENCY_EN
    logic [CNT_W-1:0] r_lat;
    logic [CNT_W-1:0] w_lat_inc;

    assign w_lat_inc = (r_lat == {CNT_W{1'b1}}) ? r_lat : r_lat + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lat      <= '0;
            rsp_cycles <= '0;
        end else if (w_accept) begin
            r_lat <= '0;
        end else if (r_state == S_ISSUE) begin
            r_lat <= w_lat_inc;
            if (w_issue_done) begin
                rsp_cycles <= w_lat_inc;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcpi_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcpi_cmd_initiator
// Description : Directed self-checking bench for pcpi_cmd_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcpi_cmd_initiator;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_insn;
    logic [31:0] cmd_rs1;
    logic [31:0] cmd_rs2;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd;
    logic        rsp_wr;
    logic        rsp_err;
`ifdef PCPI_INIT_LATENCY_EN
    logic [7:0]  rsp_cycles;
`endif

    int nchk = 0;
    int nerr = 0;
    int vcnt = 0;

    always #5 clk = ~clk;

    pcpi_cmd_initiator #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_insn   (cmd_insn),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rd     (rsp_rd),
        .rsp_wr     (rsp_wr),
        .rsp_err    (rsp_err)
`ifdef PCPI_INIT_LATENCY_EN
        ,
        .rsp_cycles (rsp_cycles)
`endif
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        cmd_valid = 1'b1;
        cmd_insn  = i;
        cmd_rs1   = a;
        cmd_rs2   = b;
    endtask

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0; rsp_ready = 1'b0;

        // Reset state
        repeat (2) nx();
        chk1 ("rst_cmd_ready",  cmd_ready,  1'b1);
        chk1 ("rst_pcpi_valid", pcpi_valid, 1'b0);
        chk1 ("rst_rsp_valid",  rsp_valid,  1'b0);
        chk32("rst_pcpi_insn",  pcpi_insn,  32'd0);
        chk32("rst_rsp_rd",     rsp_rd,     32'd0);
        chk1 ("rst_rsp_err",    rsp_err,    1'b0);
        resetn = 1'b1;
        nx();

        // 1: registered one-cycle responder
        chk1("t1_cmd_ready_c0", cmd_ready, 1'b1);
        send(32'h0200000B, 32'h00000303, 32'h00000505);
        nx();
        chk1 ("t1_pcpi_valid_c1", pcpi_valid, 1'b1);
        chk32("t1_pcpi_insn",     pcpi_insn,  32'h0200000B);
        chk32("t1_pcpi_rs1",      pcpi_rs1,   32'h00000303);
        chk32("t1_pcpi_rs2",      pcpi_rs2,   32'h00000505);
        chk1 ("t1_cmd_ready_c1",  cmd_ready,  1'b0);
        cmd_valid = 1'b0;
        nx();
        chk1("t1_rsp_valid_c2", rsp_valid, 1'b0);
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h0000000F;
        nx();
        chk1 ("t1_rsp_valid_c3",  rsp_valid,  1'b1);
        chk32("t1_rsp_rd",        rsp_rd,     32'h0000000F);
        chk1 ("t1_rsp_wr",        rsp_wr,     1'b1);
        chk1 ("t1_rsp_err",       rsp_err,    1'b0);
        chk1 ("t1_pcpi_valid_c3", pcpi_valid, 1'b0);
        pcpi_rd = 32'hDEADBEEF;
        rsp_ready = 1'b1;
        nx();
        chk1 ("t1_gap_rsp_valid", rsp_valid, 1'b0);
        chk1 ("t1_gap_cmd_ready", cmd_ready, 1'b0);
        chk32("t1_dup_ignored",   rsp_rd,    32'h0000000F);
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
        nx();
        chk1("t1_idle_cmd_ready", cmd_ready, 1'b1);

        // 2: no responder, timeout after TIMEOUT cycles of pcpi_valid
        send(32'h0000700B, 32'h1, 32'h2);
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            nx();
            if (i == 0) cmd_valid = 1'b0;
            if (pcpi_valid) vcnt++;
        end
        chk1("t2_no_early_rsp", rsp_valid, 1'b0);
        nx();
        chk32("t2_valid_cycles", 32'(vcnt), 32'd16);
        chk1 ("t2_pcpi_valid",   pcpi_valid, 1'b0);
        chk1 ("t2_rsp_valid",    rsp_valid,  1'b1);
        chk1 ("t2_rsp_err",      rsp_err,    1'b1);
        chk32("t2_rsp_rd",       rsp_rd,     32'd0);
        chk1 ("t2_rsp_wr",       rsp_wr,     1'b0);
        nx();
        nx();
        chk1("t2_idle_cmd_ready", cmd_ready, 1'b1);

        // 3: responder busy 40 cycles, then ready
        rsp_ready = 1'b0;
        send(32'h0400000B, 32'h3, 32'h4);
        nx();
        cmd_valid = 1'b0;
        pcpi_wait = 1'b1;
        repeat (40) nx();
        chk1("t3_still_valid", pcpi_valid, 1'b1);
        chk1("t3_no_timeout",  rsp_valid,  1'b0);
        pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h12345678;
        nx();
        chk1 ("t3_rsp_valid", rsp_valid, 1'b1);
        chk32("t3_rsp_rd",    rsp_rd,    32'h12345678);
        chk1 ("t3_rsp_err",   rsp_err,   1'b0);
        chk1 ("t3_rsp_wr",    rsp_wr,    1'b1);
`ifdef PCPI_INIT_LATENCY_EN
        chk32("t3_rsp_cycles", 32'(rsp_cycles), 32'd41);
`endif

        // 4: back-pressure with cmd_valid held and stray ready pulses
        send(32'h0600000B, 32'h11, 32'h22);
        for (int i = 0; i < 10; i++) begin
            chk1 ("t4_rsp_valid_held", rsp_valid,  1'b1);
            chk32("t4_rsp_rd_held",    rsp_rd,     32'h12345678);
            chk1 ("t4_cmd_ready_low",  cmd_ready,  1'b0);
            chk1 ("t4_no_pcpi_valid",  pcpi_valid, 1'b0);
            pcpi_ready = ((i % 2) == 0);
            pcpi_rd    = 32'hFFFFFFFF;
            pcpi_wr    = 1'b1;
            nx();
        end
        chk1("t4_rsp_valid_end", rsp_valid, 1'b1);
        rsp_ready  = 1'b1;
        pcpi_ready = 1'b1;
        nx();
        chk1("t4_gap_rsp_valid",  rsp_valid,  1'b0);
        chk1("t4_gap_cmd_ready",  cmd_ready,  1'b0);
        chk1("t4_gap_pcpi_valid", pcpi_valid, 1'b0);
        nx();
        chk1("t4_idle_cmd_ready",  cmd_ready,  1'b1);
        chk1("t4_idle_pcpi_valid", pcpi_valid, 1'b0);
        pcpi_ready = 1'b0;
        nx();
        chk1 ("t4_second_valid", pcpi_valid, 1'b1);
        chk32("t4_second_insn",  pcpi_insn,  32'h0600000B);
        chk32("t4_second_rs1",   pcpi_rs1,   32'h00000011);
        cmd_valid = 1'b0;

        // 5a: ready without write
        pcpi_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = 32'hFFFFFFFF;
        nx();
        chk1 ("t5_rsp_valid", rsp_valid, 1'b1);
        chk32("t5_rsp_rd",    rsp_rd,    32'd0);
        chk1 ("t5_rsp_wr",    rsp_wr,    1'b0);
        chk1 ("t5_rsp_err",   rsp_err,   1'b0);
        pcpi_ready = 1'b0;
        nx();
        nx();

        // 5b: ready on the timeout cycle
        send(32'h0800000B, 32'h3, 32'h4);
        for (int i = 0; i < 16; i++) begin
            nx();
            if (i == 0) cmd_valid = 1'b0;
        end
        chk1("t5b_pre_rsp_valid",  rsp_valid,  1'b0);
        chk1("t5b_pre_pcpi_valid", pcpi_valid, 1'b1);
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hA5A5A5A5;
        nx();
        chk1 ("t5b_rsp_valid", rsp_valid, 1'b1);
        chk1 ("t5b_rsp_err",   rsp_err,   1'b0);
        chk32("t5b_rsp_rd",    rsp_rd,    32'hA5A5A5A5);
        chk1 ("t5b_rsp_wr",    rsp_wr,    1'b1);
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        nx();
        nx();

        // 6: reset asserted mid-ISSUE
        send(32'h0A00000B, 32'h5, 32'h6);
        nx();
        cmd_valid = 1'b0;
        chk1("t6_pcpi_valid_pre", pcpi_valid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk1 ("t6_async_drop", pcpi_valid, 1'b0);
        chk32("t6_insn_clear", pcpi_insn,  32'd0);
        nx();
        resetn = 1'b1;
        nx();
        chk1("t6_no_rsp",       rsp_valid, 1'b0);
        chk1("t6_cmd_ready",    cmd_ready, 1'b1);
        send(32'h0200000B, 32'h7, 32'h8);
        nx();
        cmd_valid = 1'b0;
        chk1("t6_new_valid", pcpi_valid, 1'b1);
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h00000038;
        nx();
        chk1 ("t6_new_rsp_valid", rsp_valid, 1'b1);
        chk32("t6_new_rsp_rd",    rsp_rd,    32'h00000038);
        chk1 ("t6_new_rsp_err",   rsp_err,   1'b0);
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        nx();
        nx();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
